// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM built-in self-test: default geometry,
// base data pattern and the march state encoding.
package sram_pkg;

   localparam int          SRAM_ADDR_W  = 8;
   localparam int          SRAM_DATA_W  = 32;
   localparam logic [31:0] SRAM_PATTERN = 32'hA5A5_A5A5;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      W0   = 3'd1,
      R0   = 3'd2,
      R0D  = 3'd3,
      W1   = 3'd4,
      R1   = 3'd5,
      R1D  = 3'd6,
      DONE = 3'd7
   } bist_state_t;

endpackage

// File: rtl/sram_bist_cmp.sv
// Read-data checker: holds the expected word and address of the read issued
// last cycle, compares it against returned data and captures the first failure.
module sram_bist_cmp
   import sram_pkg::*;
#(
   parameter int                ADDR_W  = SRAM_ADDR_W,
   parameter int                DATA_W  = SRAM_DATA_W,
   parameter logic [DATA_W-1:0] PATTERN = SRAM_PATTERN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              issue,
   input  logic [ADDR_W-1:0] issue_addr,
   input  logic              inv,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mismatch,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data
);

   logic              pend_valid;
   logic [ADDR_W-1:0] pend_addr;
   logic [DATA_W-1:0] pend_exp;

   function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a,
                                                  input logic inv_pat);
      logic [DATA_W-1:0] e;
      e = PATTERN ^ DATA_W'(a);
      return inv_pat ? ~e : e;
   endfunction

   assign mismatch = pend_valid && (mem_rdata != pend_exp);

   // A mismatch kills the pipeline so the read still in flight is never judged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid <= 1'b0;
         pend_addr  <= '0;
         pend_exp   <= '0;
         fail_addr  <= '0;
         fail_data  <= '0;
      end else begin
         pend_valid <= issue && !mismatch && !clear;
         pend_addr  <= issue_addr;
         pend_exp   <= exp_data(issue_addr, inv);
         if (clear) begin
            fail_addr <= '0;
            fail_data <= '0;
         end else if (mismatch) begin
            fail_addr <= pend_addr;
            fail_data <= mem_rdata;
         end
      end
   end

endmodule

// File: rtl/sram_bist.sv
// Two-pass write/read-back march BIST for a single-port SRAM; reports
// pass/fail together with the first failing address and read data.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   W0    | write pattern ascending
//   R0    | read/compare pattern ascending
//   R0D   | drain: compare last ascending read
//   W1    | write inverted pattern descending
//   R1    | read/compare inverted pattern descending
//   R1D   | drain: compare last descending read
//   DONE  | results held until next start
module sram_bist
   import sram_pkg::*;
#(
   parameter int                ADDR_W  = SRAM_ADDR_W,
   parameter int                DATA_W  = SRAM_DATA_W,
   parameter logic [DATA_W-1:0] PATTERN = SRAM_PATTERN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data,
   output logic [31:0]       mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   bist_state_t       state;
   logic [ADDR_W-1:0] addr;
   logic              start_acc;
   logic              mismatch;

   function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a,
                                                  input logic inv_pat);
      logic [DATA_W-1:0] e;
      e = PATTERN ^ DATA_W'(a);
      return inv_pat ? ~e : e;
   endfunction

   assign start_acc = start && ((state == IDLE) || (state == DONE));
   assign mem_addr  = 32'(addr);

   sram_bist_cmp #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .PATTERN (PATTERN)
   ) u_cmp (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (start_acc),
      .issue      (mem_re),
      .issue_addr (addr),
      .inv        (state == R1),
      .mem_rdata  (mem_rdata),
      .mismatch   (mismatch),
      .fail_addr  (fail_addr),
      .fail_data  (fail_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= W0;
                  addr      <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  mem_we    <= 1'b1;
                  mem_wdata <= exp_data('0, 1'b0);
               end
            end
            W0: begin
               if (addr == ADDR_MAX) begin
                  state  <= R0;
                  addr   <= '0;
                  mem_we <= 1'b0;
                  mem_re <= 1'b1;
               end else begin
                  addr      <= addr + ADDR_ONE;
                  mem_wdata <= exp_data(addr + ADDR_ONE, 1'b0);
               end
            end
            R0: begin
               if (mismatch) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  pass   <= 1'b0;
                  mem_re <= 1'b0;
               end else if (addr == ADDR_MAX) begin
                  state  <= R0D;
                  mem_re <= 1'b0;
               end else begin
                  addr <= addr + ADDR_ONE;
               end
            end
            R0D: begin
               if (mismatch) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= 1'b0;
               end else begin
                  state     <= W1;
                  addr      <= ADDR_MAX;
                  mem_we    <= 1'b1;
                  mem_wdata <= exp_data(ADDR_MAX, 1'b1);
               end
            end
            W1: begin
               if (addr == '0) begin
                  state  <= R1;
                  addr   <= ADDR_MAX;
                  mem_we <= 1'b0;
                  mem_re <= 1'b1;
               end else begin
                  addr      <= addr - ADDR_ONE;
                  mem_wdata <= exp_data(addr - ADDR_ONE, 1'b1);
               end
            end
            R1: begin
               if (mismatch) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  pass   <= 1'b0;
                  mem_re <= 1'b0;
               end else if (addr == '0) begin
                  state  <= R1D;
                  mem_re <= 1'b0;
               end else begin
                  addr <= addr - ADDR_ONE;
               end
            end
            R1D: begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
               pass  <= !mismatch;
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               mem_we <= 1'b0;
               mem_re <= 1'b0;
            end
         endcase
      end
   end

endmodule
